// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer: phase encoding and default widths.
package pwm_pkg;

    localparam int R_DEFAULT = 8;
    localparam int PHASE_W   = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_OFF     = 3'd0,
        PH_UP      = 3'd1,
        PH_HOLD_HI = 3'd2,
        PH_DOWN    = 3'd3,
        PH_HOLD_LO = 3'd4
    } phase_t;

endpackage

// File: rtl/pwm_tick_div.sv
// Prescaler: emits a step strobe on every DIV-th PWM period tick; clr restarts the count.
module pwm_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clr,
    output logic step
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign step = tick && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Triangular "breathing" duty sequencer advancing on PWM period ticks.
// Optional perceptual gamma on the duty output when PWM_RAMP_GAMMA_EN is defined.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int R    = R_DEFAULT,
    parameter int STEP = 1,
    parameter int DIV  = 4,
    parameter int HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               tick,
    output logic [R-1:0]       duty,
    output logic               duty_upd,
    output logic [PHASE_W-1:0] phase
);

    localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_V  = HW'(HOLD);
    localparam logic [R-1:0]  LVL_MAX = {R{1'b1}};
    localparam logic [R-1:0]  STEP_V  = R'(STEP);

    function automatic logic [R-1:0] step_up(input logic [R-1:0] l);
        logic [R:0] s;
        s = {1'b0, l} + (R+1)'(STEP);
        return s[R] ? LVL_MAX : s[R-1:0];
    endfunction

    function automatic logic [R-1:0] step_dn(input logic [R-1:0] l);
        return (l >= STEP_V) ? l - STEP_V : '0;
    endfunction

    function automatic logic [R-1:0] shape(input logic [R-1:0] l);
`ifdef PWM_RAMP_GAMMA_EN
        logic [2*R-1:0] p;
        p = {{R{1'b0}}, l} * {{R{1'b0}}, l};
        return R'(p >> R);
`else
        return l;
`endif
    endfunction

    // Reset asserts immediately but releases only after two clean clock edges.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    phase_t        state, state_d;
    logic [R-1:0]  level, level_d, duty_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic          counting, div_tick, div_clr, step;

    // The prescaler only runs while ramping; any other tick restarts it from zero.
    assign counting = (state == PH_UP) || (state == PH_DOWN);
    assign div_tick = tick && run && counting;
    assign div_clr  = tick && !(run && counting);

    pwm_tick_div #(.DIV(DIV)) u_div (
        .clk   (clk),
        .reset (rst_n),
        .tick  (div_tick),
        .clr   (div_clr),
        .step  (step)
    );

    always_comb begin
        state_d = state;
        level_d = level;
        hold_d  = hold_cnt;
        if (tick) begin
            if (!run) begin
                state_d = PH_OFF;
                level_d = '0;
                hold_d  = '0;
            end else begin
                case (state)
                    PH_OFF: begin
                        state_d = PH_UP;
                        level_d = '0;
                        hold_d  = '0;
                    end
                    PH_UP: if (step) begin
                        level_d = step_up(level);
                        if (level_d == LVL_MAX) state_d = PH_HOLD_HI;
                    end
                    PH_DOWN: if (step) begin
                        level_d = step_dn(level);
                        if (level_d == '0) state_d = PH_HOLD_LO;
                    end
                    PH_HOLD_HI, PH_HOLD_LO: begin
                        if (hold_cnt == HOLD_V) begin
                            hold_d  = '0;
                            state_d = (state == PH_HOLD_HI) ? PH_DOWN : PH_UP;
                        end else begin
                            hold_d = hold_cnt + HW'(1);
                        end
                    end
                    default: begin
                        state_d = PH_OFF;
                        level_d = '0;
                        hold_d  = '0;
                    end
                endcase
            end
        end
    end

    assign duty_d = shape(level_d);

    // Duty is registered from the next level so it lands on the same edge as the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PH_OFF;
            level    <= '0;
            hold_cnt <= '0;
            duty     <= '0;
            duty_upd <= 1'b0;
        end else begin
            state    <= state_d;
            level    <= level_d;
            hold_cnt <= hold_d;
            duty     <= duty_d;
            duty_upd <= (duty_d != duty);
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: three instances cover ramp/hold/stop, clamp/prescale, reset/long ramp.
module tb_pwm_duty_ramp;
    import pwm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

`ifdef PWM_RAMP_GAMMA_EN
    function automatic int g(input int lvl, input int r);
        return (lvl * lvl) >> r;
    endfunction
`else
    function automatic int g(input int lvl, input int r);
        return lvl + 0 * r;
    endfunction
`endif

    // Instance A: R=4 STEP=1 DIV=1 HOLD=2
    logic       reset_ab, run_a, tick_a, upd_a;
    logic [3:0] duty_a;
    logic [2:0] phase_a;
    pwm_duty_ramp #(.R(4), .STEP(1), .DIV(1), .HOLD(2)) u_a (
        .clk(clk), .reset(reset_ab), .run(run_a), .tick(tick_a),
        .duty(duty_a), .duty_upd(upd_a), .phase(phase_a));

    // Instance B: R=4 STEP=6 DIV=3 HOLD=0
    logic       run_b, tick_b, upd_b;
    logic [3:0] duty_b;
    logic [2:0] phase_b;
    pwm_duty_ramp #(.R(4), .STEP(6), .DIV(3), .HOLD(0)) u_b (
        .clk(clk), .reset(reset_ab), .run(run_b), .tick(tick_b),
        .duty(duty_b), .duty_upd(upd_b), .phase(phase_b));

    // Instance C: R=8 STEP=1 DIV=1 HOLD=0
    logic       reset_c, run_c, tick_c, upd_c;
    logic [7:0] duty_c;
    logic [2:0] phase_c;
    pwm_duty_ramp #(.R(8), .STEP(1), .DIV(1), .HOLD(0)) u_c (
        .clk(clk), .reset(reset_c), .run(run_c), .tick(tick_c),
        .duty(duty_c), .duty_upd(upd_c), .phase(phase_c));

    int exp_a[$];
    int exp_b[$];
    int last_a = 0;
    int last_b = 0;

    task automatic push_a(input int lvl);
        int v = g(lvl, 4);
        if (v != last_a) begin
            exp_a.push_back(v);
            last_a = v;
        end
    endtask

    task automatic push_b(input int lvl);
        int v = g(lvl, 4);
        if (v != last_b) begin
            exp_b.push_back(v);
            last_b = v;
        end
    endtask

    // Monitor: every duty_upd must match the next expected value in order.
    always @(negedge clk) begin
        if (upd_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_upd: unexpected update to %0d, required no update", duty_a);
            end else begin
                check("a_upd_duty", int'(duty_a), exp_a.pop_front());
            end
        end
        if (upd_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_upd: unexpected update to %0d, required no update", duty_b);
            end else begin
                check("b_upd_duty", int'(duty_b), exp_b.pop_front());
            end
        end
    end

    task automatic ticks_a(input int n);
        repeat (n) begin
            @(posedge clk); #1 tick_a = 1'b1;
            @(posedge clk); #1 tick_a = 1'b0;
            repeat (8) @(posedge clk);
        end
        #1;
    endtask

    task automatic ticks_b(input int n);
        repeat (n) begin
            @(posedge clk); #1 tick_b = 1'b1;
            @(posedge clk); #1 tick_b = 1'b0;
            repeat (8) @(posedge clk);
        end
        #1;
    endtask

    // Continuous tick: one tick per clock for n clocks.
    task automatic burst_c(input int n);
        @(posedge clk); #1 tick_c = 1'b1;
        repeat (n) @(posedge clk);
        #1 tick_c = 1'b0;
    endtask

    int tab_b[24] = '{0, 0, 0, 6, 6, 6, 12, 12, 12, 15, 15, 15,
                      15, 9, 9, 9, 3, 3, 3, 0, 0, 0, 0, 6};

    initial begin
        reset_ab = 1'b0; reset_c = 1'b0;
        run_a = 1'b0; run_b = 1'b0; run_c = 1'b0;
        tick_a = 1'b0; tick_b = 1'b0; tick_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty_a", int'(duty_a), 0);
        check("rst_upd_a", int'(upd_a), 0);
        check("rst_phase_a", int'(phase_a), int'(PH_OFF));
        check("rst_duty_b", int'(duty_b), 0);
        check("rst_phase_b", int'(phase_b), int'(PH_OFF));
        check("rst_duty_c", int'(duty_c), 0);
        reset_ab = 1'b1; reset_c = 1'b1;
        repeat (4) @(posedge clk);

        // Basic ramp with hold, A
        run_a = 1'b1;
        ticks_a(1);
        check("a_enter_up", int'(phase_a), int'(PH_UP));
        check("a_first_tick_duty", int'(duty_a), g(0, 4));
        for (int l = 1; l <= 15; l++) push_a(l);
        ticks_a(15);
        check("a_hold_hi", int'(phase_a), int'(PH_HOLD_HI));
        check("a_top_duty", int'(duty_a), g(15, 4));
        ticks_a(2);
        check("a_still_hold_hi", int'(phase_a), int'(PH_HOLD_HI));
        ticks_a(1);
        check("a_enter_down", int'(phase_a), int'(PH_DOWN));
        check("a_top_held", int'(duty_a), g(15, 4));
        for (int l = 14; l >= 0; l--) push_a(l);
        ticks_a(15);
        check("a_hold_lo", int'(phase_a), int'(PH_HOLD_LO));
        ticks_a(3);
        check("a_reenter_up", int'(phase_a), int'(PH_UP));
        for (int l = 1; l <= 9; l++) push_a(l);
        ticks_a(9);
        check("a_level9", int'(duty_a), g(9, 4));

        // Stop on the same tick that would step
        push_a(0);
        @(posedge clk); #1 run_a = 1'b0; tick_a = 1'b1;
        @(posedge clk); #1 tick_a = 1'b0;
        check("a_stop_phase", int'(phase_a), int'(PH_OFF));
        check("a_stop_duty", int'(duty_a), 0);
        repeat (5) @(posedge clk);
        #1 run_a = 1'b1;
        ticks_a(1);
        check("a_restart_up", int'(phase_a), int'(PH_UP));
        check("a_restart_duty", int'(duty_a), 0);
        push_a(1);
        ticks_a(1);
        check("a_restart_step", int'(duty_a), g(1, 4));
        // run toggled between ticks has no effect
        run_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 run_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("a_run_no_tick_phase", int'(phase_a), int'(PH_UP));
        check("a_run_no_tick_duty", int'(duty_a), g(1, 4));

        // Clamp and prescale, B
        foreach (tab_b[i]) push_b(tab_b[i]);
        run_b = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ticks_b(1);
            check($sformatf("b_tick%0d", i + 1), int'(duty_b), g(tab_b[i], 4));
        end
        check("b_phase_up", int'(phase_b), int'(PH_UP));
        repeat (100) @(posedge clk);
        #1;
        check("b_idle_duty", int'(duty_b), g(6, 4));

        // Reset mid-ramp, C
        run_c = 1'b1;
        burst_c(38);
        check("c_level37", int'(duty_c), g(37, 8));
        check("c_phase_up", int'(phase_c), int'(PH_UP));
        #2 reset_c = 1'b0;
        #1;
        check("c_async_duty", int'(duty_c), 0);
        check("c_async_phase", int'(phase_c), int'(PH_OFF));
        check("c_async_upd", int'(upd_c), 0);
        repeat (2) @(posedge clk);
        #1 reset_c = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("c_released_duty", int'(duty_c), 0);
        burst_c(2);
        check("c_restart_duty", int'(duty_c), g(1, 8));
        check("c_restart_phase", int'(phase_c), int'(PH_UP));
        burst_c(127);
        check("c_level128", int'(duty_c), g(128, 8));
        burst_c(127);
        check("c_level255", int'(duty_c), g(255, 8));
        check("c_hold_hi", int'(phase_c), int'(PH_HOLD_HI));

        repeat (10) @(posedge clk);
        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Duty-cycle sequencer that sits directly upstream of the basic PWM generator and drives its duty input. Produces a triangular "breathing" duty profile: ramps 0 → max, holds, ramps max → 0, holds, repeats. Updates only on PWM period boundaries, so the PWM never sees a duty change mid-period. Counters and the FSM advance on a one-cycle period tick supplied by the PWM stage.

## Interface
- R, 8: duty width in bits, matching the PWM stage's R.
- STEP, 1: duty increment/decrement per step, 1..2^R-1.
- DIV, 4: PWM periods per step, ≥1.
- HOLD, 16: PWM periods held at each extreme, ≥0.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = sequence runs, 0 = go dark.
- tick  in  1  one-cycle pulse at each PWM period boundary.
- duty  out  R  duty level for the PWM stage, registered.
- duty_upd  out  1  one-cycle pulse in the cycle `duty` takes a new value.
- phase  out  3  current state encoding, for debug and LEDs.

## Operation
- States: OFF=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.
- Internal: `level` [R-1:0], `div_cnt` counting 0..DIV-1, `hold_cnt` counting 0..HOLD.
- All transitions and counter updates occur only on clock edges where `tick`=1. Exception: `run`=0 forces OFF on the next tick.
- OFF:
  - level=0, counters cleared.
  - On a tick with run=1 → UP; no level change on that tick.
- UP: each tick increments div_cnt. When div_cnt==DIV-1, div_cnt→0 and one step is taken.
  - Step: level ← min(level+STEP, 2^R-1), computed in R+1 bits then clamped.
  - If the clamped result is 2^R-1 → HOLD_HI.
- HOLD_HI: hold_cnt increments per tick. At hold_cnt==HOLD → DOWN, hold_cnt→0. HOLD=0 gives a one-tick pass-through.
- DOWN: mirror of UP. Step: level ← level≥STEP ? level-STEP : 0. Reaching 0 → HOLD_LO.
- HOLD_LO: as HOLD_HI, then → UP.
- run=0 on a tick, in any state: → OFF and level←0. This has priority over every other transition on the same tick.
- run changes without a tick have no effect until the next tick.
- duty_upd is 1 exactly when the registered duty differs from its previous value. This includes the drop to 0 on entering OFF.

## Timing
- Reset values: duty=0, duty_upd=0, phase=OFF, all counters 0.
- Reset is asynchronous on assertion and released synchronously to clk. Asserting it mid-ramp clears all state immediately.
- Latency: duty and duty_upd change on the same clk edge that samples tick=1. Visible 1 cycle after the tick cycle, i.e. before the PWM's first counter step of the new period.
- Full up-ramp takes ceil((2^R-1)/STEP)·DIV ticks.
- Full cycle takes 2·ramp + 2·(HOLD+1) ticks.
- tick held high for multiple cycles is treated as one tick per cycle (no edge detect).

## Configuration
- PWM_RAMP_GAMMA_EN defined: duty = (level·level) >> R, a 2R-bit product truncated to the top R bits. Gives perceptual brightness correction.
  - Registered, same latency as above.
  - duty_upd is based on the corrected value, so it is not asserted for steps where the corrected value is unchanged.
- Undefined: duty = level directly; no multiplier is synthesized.

## Structure
- Shared package `pwm_pkg`: state encoding constants (OFF..HOLD_LO), default R, and the phase width.
- Sub-module `pwm_tick_div`: DIV prescaler producing a step strobe from tick. Clear input driven on state entry.
- FSM, level arithmetic and gamma stage live in the top module.

## Test plan
- Reset mid-ramp: R=8, STEP=1, DIV=1; drop reset at level=37 → duty=0 and phase=OFF immediately, asynchronously; after release, restart from 0.
- Basic ramp: R=4, STEP=1, DIV=1, HOLD=2, run=1, tick every 10 cycles → duty 0,1..15; 3 ticks at 15; 14..0; 3 ticks at 0; repeat. One duty_upd per change.
- Clamp: R=4, STEP=6 → up 0,6,12,15; down 15,9,3,0. No wrap past 15 or below 0.
- Prescale: DIV=3 → duty changes on every 3rd tick only. With no ticks for 100 cycles, duty stays constant.
- Stop priority: run→0 on the same cycle as a step tick at level 9 → duty=0, phase=OFF, one duty_upd. run→1 → UP on the next tick.
- Gamma (PWM_RAMP_GAMMA_EN, R=8): level 128 → duty 64; level 255 → duty 254; level 15 → duty 0.
